// File: rtl/snake_pkg.sv
// ---------------------------------------------------------------------------
// snake_pkg
// Shared definitions for the snake game controller:
//   - state_t      : 2-bit game state encoding (IDLE/SPAWN/PLAY/OVER)
//   - SCREEN_W/H   : screen dimensions, used for the reset apple position
//   - HIT_RADIUS_DEF : default eat window half-width
//   - LFSR_TAPS    : feedback mask for x^20 + x^17 + 1
//   - abs_diff()   : |a - b| of two 10-bit unsigned coordinates
// ---------------------------------------------------------------------------
package snake_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SPAWN = 2'd1,
        S_PLAY  = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    localparam int unsigned SCREEN_W       = 640;
    localparam int unsigned SCREEN_H       = 480;
    localparam int unsigned HIT_RADIUS_DEF = 10;

    // Bits 19 and 16 feed the XOR (polynomial x^20 + x^17 + 1).
    localparam logic [19:0] LFSR_TAPS = 20'h90000;

    // Magnitude of the 11-bit signed difference; always fits in 10 bits.
    function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
        logic signed [10:0] d;
        logic signed [10:0] nd;
        d  = $signed({1'b0, a}) - $signed({1'b0, b});
        nd = -d;
        return d[10] ? nd[9:0] : d[9:0];
    endfunction

endpackage

// File: rtl/snake_lfsr20.sv
// ---------------------------------------------------------------------------
// snake_lfsr20
// 20-bit Fibonacci LFSR (x^20 + x^17 + 1) used as the apple position source.
// A nonzero seed keeps it out of the all-zero lock-up state.
// Ports:
//   clock    in   system clock
//   reset    in   asynchronous, active-high; loads SEED
//   en_i     in   shift enable
//   lfsr_o   out  current 20-bit register state
// ---------------------------------------------------------------------------
module snake_lfsr20
    import snake_pkg::*;
#(
    parameter logic [19:0] SEED = 20'hACE1F
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        en_i,
    output logic [19:0] lfsr_o
);

    logic [19:0] lfsr_q;
    logic [19:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (en_i) begin
            lfsr_d = {lfsr_q[18:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/snake_game_controller.sv
// ---------------------------------------------------------------------------
// snake_game_controller
// Game-level controller downstream of the snake position stage. Runs the
// IDLE/SPAWN/PLAY/OVER FSM, detects apple eats, places apples from an LFSR,
// and keeps score, length and the velocity ramp. All outputs are registered.
//
// Optional feature macro: SNAKE_APPLE_TIMEOUT_EN
//   Defined  : an uneaten apple is respawned after APPLE_TIMEOUT_TICKS ticks
//              in PLAY (collision and eat win over timeout on the same tick).
//   Undefined: the apple persists until eaten.
//
// Ports:
//   clock      in   system clock
//   reset      in   asynchronous, active-high
//   tick       in   one-cycle game-step strobe
//   start      in   start/restart request (level)
//   head_x/y   in   snake head coordinate (10 bits each)
//   collision  in   wall/self collision flag
//   length     out  snake length
//   velocity   out  pixels per step
//   x_apple/y_apple out apple coordinate
//   score      out  apples eaten (saturating)
//   game_over  out  high in OVER
//   state      out  IDLE=0, SPAWN=1, PLAY=2, OVER=3
// ---------------------------------------------------------------------------
module snake_game_controller
    import snake_pkg::*;
#(
    parameter int unsigned INIT_LEN            = 3,
    parameter int unsigned MAX_LEN             = 99,
    parameter int unsigned HIT_RADIUS          = HIT_RADIUS_DEF,
    parameter int unsigned X_MIN               = 20,
    parameter int unsigned X_MAX               = 619,
    parameter int unsigned Y_MIN               = 20,
    parameter int unsigned Y_MAX               = 459,
    parameter int unsigned SPEED_STEP          = 5,
    parameter int unsigned VEL_MAX             = 8,
    parameter logic [19:0] LFSR_SEED           = 20'hACE1F,
    parameter int unsigned APPLE_TIMEOUT_TICKS = 600
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        tick,
    input  logic        start,
    input  logic [9:0]  head_x,
    input  logic [9:0]  head_y,
    input  logic        collision,
    output logic [9:0]  length,
    output logic [3:0]  velocity,
    output logic [9:0]  x_apple,
    output logic [9:0]  y_apple,
    output logic [15:0] score,
    output logic        game_over,
    output logic [1:0]  state
);

    localparam logic [9:0]  INIT_LEN_C = 10'(INIT_LEN);
    localparam logic [9:0]  MAX_LEN_C  = 10'(MAX_LEN);
    localparam logic [9:0]  HIT_C      = 10'(HIT_RADIUS);
    localparam logic [9:0]  SPAWN_D_C  = 10'(2 * HIT_RADIUS);
    localparam logic [9:0]  X_MIN_C    = 10'(X_MIN);
    localparam logic [9:0]  X_MAX_C    = 10'(X_MAX);
    localparam logic [9:0]  Y_MIN_C    = 10'(Y_MIN);
    localparam logic [9:0]  Y_MAX_C    = 10'(Y_MAX);
    localparam logic [15:0] STEP_C     = 16'(SPEED_STEP);
    localparam logic [3:0]  VEL_MAX_C  = 4'(VEL_MAX);
    localparam logic [9:0]  APPLE_X0   = 10'(SCREEN_W * 3 / 4);
    localparam logic [9:0]  APPLE_Y0   = 10'(SCREEN_H / 2);

    state_t      state_q, state_d;
    logic [9:0]  length_q, length_d;
    logic [3:0]  vel_q, vel_d;
    logic [9:0]  xa_q, xa_d;
    logic [9:0]  ya_q, ya_d;
    logic [15:0] score_q, score_d;
    logic        go_q;

    logic [19:0] lfsr;
    logic [9:0]  cx, cy;
    logic        cand_ok;
    logic        eat;
    logic        timeout_hit;
    logic [15:0] score_inc;
    logic        unused_lfsr;

    // Free-running: advances every clock regardless of state.
    snake_lfsr20 #(.SEED(LFSR_SEED)) u_lfsr (
        .clock  (clock),
        .reset  (reset),
        .en_i   (1'b1),
        .lfsr_o (lfsr)
    );

    assign cx          = lfsr[9:0];
    assign cy          = {1'b0, lfsr[18:10]};
    assign unused_lfsr = lfsr[19];

    // Candidate must be on the legal field and clear of the head on some axis.
    assign cand_ok = (cx >= X_MIN_C) && (cx <= X_MAX_C) &&
                     (cy >= Y_MIN_C) && (cy <= Y_MAX_C) &&
                     ((abs_diff(cx, head_x) >= SPAWN_D_C) ||
                      (abs_diff(cy, head_y) >= SPAWN_D_C));

    assign eat = (abs_diff(head_x, xa_q) < HIT_C) && (abs_diff(head_y, ya_q) < HIT_C);

    assign score_inc = (score_q == 16'hFFFF) ? score_q : score_q + 16'd1;

`ifdef SNAKE_APPLE_TIMEOUT_EN
    localparam logic [9:0] TIMEOUT_C = 10'(APPLE_TIMEOUT_TICKS);

    logic [9:0] tcnt_q, tcnt_d, tcnt_inc;

    assign tcnt_inc    = tcnt_q + 10'd1;
    assign timeout_hit = (tcnt_inc == TIMEOUT_C);

    // Held at zero outside PLAY, so every entry to PLAY starts a fresh count.
    always_comb begin
        tcnt_d = tcnt_q;
        if (state_q != S_PLAY) begin
            tcnt_d = '0;
        end else if (tick) begin
            tcnt_d = tcnt_inc;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tcnt_q <= '0;
        end else begin
            tcnt_q <= tcnt_d;
        end
    end
`else
    logic unused_timeout;
    assign timeout_hit    = 1'b0;
    assign unused_timeout = (APPLE_TIMEOUT_TICKS == 0);
`endif

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_SPAWN;
            S_SPAWN: if (cand_ok) state_d = S_PLAY;
            S_PLAY: begin
                if (tick) begin
                    if (collision)        state_d = S_OVER;
                    else if (eat)         state_d = S_SPAWN;
                    else if (timeout_hit) state_d = S_SPAWN;
                end
            end
            S_OVER:  if (start) state_d = S_SPAWN;
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        length_d = length_q;
        vel_d    = vel_q;
        xa_d     = xa_q;
        ya_d     = ya_q;
        score_d  = score_q;
        unique case (state_q)
            S_SPAWN: begin
                if (cand_ok) begin
                    xa_d = cx;
                    ya_d = cy;
                end
            end
            S_PLAY: begin
                if (tick && !collision && eat) begin
                    length_d = (length_q >= MAX_LEN_C) ? MAX_LEN_C : length_q + 10'd1;
                    score_d  = score_inc;
                    if ((score_inc % STEP_C) == 16'd0) begin
                        vel_d = (vel_q >= VEL_MAX_C) ? VEL_MAX_C : vel_q + 4'd1;
                    end
                end
            end
            S_OVER: begin
                if (start) begin
                    length_d = INIT_LEN_C;
                    vel_d    = 4'd1;
                    score_d  = 16'd0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            length_q <= INIT_LEN_C;
            vel_q    <= 4'd1;
            xa_q     <= APPLE_X0;
            ya_q     <= APPLE_Y0;
            score_q  <= 16'd0;
            go_q     <= 1'b0;
        end else begin
            length_q <= length_d;
            vel_q    <= vel_d;
            xa_q     <= xa_d;
            ya_q     <= ya_d;
            score_q  <= score_d;
            go_q     <= (state_d == S_OVER);
        end
    end

    assign length    = length_q;
    assign velocity  = vel_q;
    assign x_apple   = xa_q;
    assign y_apple   = ya_q;
    assign score     = score_q;
    assign game_over = go_q;
    assign state     = state_q;

endmodule

// File: tb/tb_snake_game_controller.sv
module tb_snake_game_controller;

`ifdef SNAKE_APPLE_TIMEOUT_EN
    localparam int TO_TICKS = 4;
    localparam bit TO_EN    = 1'b1;
`else
    localparam int TO_TICKS = 600;
    localparam bit TO_EN    = 1'b0;
`endif

    logic        clock, reset, tick, start, collision;
    logic [9:0]  head_x, head_y;
    logic [9:0]  length, x_apple, y_apple;
    logic [3:0]  velocity;
    logic [15:0] score;
    logic        game_over;
    logic [1:0]  state;

    snake_game_controller #(.APPLE_TIMEOUT_TICKS(TO_TICKS)) dut (
        .clock     (clock),
        .reset     (reset),
        .tick      (tick),
        .start     (start),
        .head_x    (head_x),
        .head_y    (head_y),
        .collision (collision),
        .length    (length),
        .velocity  (velocity),
        .x_apple   (x_apple),
        .y_apple   (y_apple),
        .score     (score),
        .game_over (game_over),
        .state     (state)
    );

    always #5 clock = ~clock;

    int nchk = 0, npass = 0, nfail = 0;

    // Reference model: game rules in plain integer arithmetic.
    int m_st, m_len, m_vel, m_x, m_y, m_score, m_tcnt, m_lf;

    function automatic int adiff(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    task automatic m_reset();
        m_st = 0; m_len = 3; m_vel = 1; m_x = 480; m_y = 240;
        m_score = 0; m_tcnt = 0; m_lf = 'hACE1F;
    endtask

    task automatic m_step();
        int n_st, cx, cy, hx, hy;
        n_st = m_st;
        hx = int'(head_x);
        hy = int'(head_y);
        case (m_st)
            0: if (start) n_st = 1;
            1: begin
                cx = m_lf % 1024;
                cy = (m_lf / 1024) % 512;
                if (cx >= 20 && cx <= 619 && cy >= 20 && cy <= 459 &&
                    (adiff(cx, hx) >= 20 || adiff(cy, hy) >= 20)) begin
                    m_x = cx; m_y = cy; m_tcnt = 0; n_st = 2;
                end
            end
            2: if (tick) begin
                if (collision) n_st = 3;
                else if (adiff(hx, m_x) < 10 && adiff(hy, m_y) < 10) begin
                    m_len   = (m_len + 1 > 99) ? 99 : m_len + 1;
                    m_score = (m_score + 1 > 65535) ? 65535 : m_score + 1;
                    if (m_score % 5 == 0) m_vel = (m_vel + 1 > 8) ? 8 : m_vel + 1;
                    n_st = 1;
                end else begin
                    m_tcnt++;
                    if (TO_EN && m_tcnt == TO_TICKS) n_st = 1;
                end
            end
            default: if (start) begin
                m_len = 3; m_vel = 1; m_score = 0; n_st = 1;
            end
        endcase
        m_st = n_st;
        m_lf = ((m_lf * 2) % 'h100000) + (((m_lf / 'h80000) ^ (m_lf / 'h10000)) % 2);
    endtask

    function automatic logic [52:0] obs_vec();
        return {state, length, velocity, x_apple, y_apple, score, game_over};
    endfunction

    function automatic logic [52:0] exp_vec();
        return {2'(m_st), 10'(m_len), 4'(m_vel), 10'(m_x), 10'(m_y), 16'(m_score), (m_st == 3)};
    endfunction

    task automatic check(input string tag, input logic [52:0] obs, input logic [52:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        m_step();
        @(posedge clock);
        #1;
        check("cycle", obs_vec(), exp_vec());
    endtask

    // Spin in SPAWN with junk on the ignored inputs until PLAY (bounded).
    task automatic wait_play();
        int n;
        n = 0;
        while (m_st != 2 && n < 300) begin
            tick      = 1'($urandom_range(0, 1));
            start     = 1'($urandom_range(0, 1));
            collision = 1'($urandom_range(0, 1));
            cyc();
            n++;
        end
        tick = 0; start = 0; collision = 0;
        check("reach_play", 53'(state), 53'd2);
    endtask

    task automatic eat_once();
        head_x = 10'(m_x + int'($urandom_range(0, 18)) - 9);
        head_y = 10'(m_y + int'($urandom_range(0, 18)) - 9);
        tick = 1;
        cyc();
        tick = 0;
    endtask

    initial begin
        int sc;
        logic in_rng, far;
        clock = 0; reset = 1; tick = 0; start = 0; collision = 0;
        head_x = 10'd320; head_y = 10'd120;
        m_reset();
        repeat (3) @(posedge clock);
        #1;
        check("reset_values", obs_vec(), {2'd0, 10'd3, 4'd1, 10'd480, 10'd240, 16'd0, 1'b0});
        reset = 0;
        #1;
        check("after_release", obs_vec(), exp_vec());

        repeat (4) cyc();
        check("idle_holds", 53'(state), 53'd0);
        start = 1; cyc(); start = 0;
        check("to_spawn", 53'(state), 53'd1);
        wait_play();
        in_rng = (x_apple >= 20) && (x_apple <= 619) && (y_apple >= 20) && (y_apple <= 459);
        far = (adiff(int'(x_apple), 320) >= 20) || (adiff(int'(y_apple), 120) >= 20);
        check("apple_range", 53'(in_rng), 53'd1);
        check("apple_clear_of_head", 53'(far), 53'd1);
        check("apple_vs_model", 53'({x_apple, y_apple}), 53'({10'(m_x), 10'(m_y)}));

        // Corner of the eat window
        head_x = 10'(m_x + 9); head_y = 10'(m_y - 9);
        tick = 1; cyc(); tick = 0;
        check("eat_len", 53'(length), 53'd4);
        check("eat_score", 53'(score), 53'd1);
        check("eat_state", 53'(state), 53'd1);
        wait_play();

        // Just outside the window
        head_x = 10'(m_x + 10); head_y = 10'(m_y);
        tick = 1; cyc(); tick = 0;
        check("edge_no_eat_state", 53'(state), 53'd2);
        check("edge_no_eat_score", 53'(score), 53'd1);

        for (int i = 0; i < 100; i++) begin
            eat_once();
            if (m_score == 5)  check("vel_after_5", 53'(velocity), 53'd2);
            if (m_score == 40) check("vel_cap", 53'(velocity), 53'd8);
            wait_play();
        end
        check("len_saturated", 53'(length), 53'd99);
        check("score_101", 53'(score), 53'd101);

        // Ticks with the head far from the apple
        head_x = 10'((m_x >= 320) ? m_x - 200 : m_x + 200);
        head_y = 10'(m_y);
        sc = m_score;
        for (int i = 0; i < 4; i++) begin
            tick = 1; cyc(); tick = 0;
            if (i < 3) cyc();
        end
        check("timeout_state", 53'(state), TO_EN ? 53'd1 : 53'd2);
        check("timeout_score", 53'(score), 53'(sc));
        wait_play();

        // Collision and eat on the same tick
        head_x = 10'(m_x); head_y = 10'(m_y);
        sc = m_score;
        collision = 1; tick = 1; cyc(); tick = 0; collision = 0;
        check("over_state", 53'(state), 53'd3);
        check("over_flag", 53'(game_over), 53'd1);
        check("over_score", 53'(score), 53'(sc));
        repeat (2) cyc();
        start = 1; cyc(); start = 0;
        check("restart", obs_vec() & {2'b11, 10'h3FF, 4'hF, 20'd0, 16'hFFFF, 1'b1},
              {2'd1, 10'd3, 4'd1, 20'd0, 16'd0, 1'b0});
        wait_play();

        // Asynchronous reset mid-PLAY
        reset = 1;
        #1;
        m_reset();
        check("async_reset", obs_vec(), {2'd0, 10'd3, 4'd1, 10'd480, 10'd240, 16'd0, 1'b0});
        @(posedge clock); #1;
        reset = 0;
        head_x = 10'd320; head_y = 10'd120;
        start = 1; cyc(); start = 0;
        wait_play();

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

// File: doc/snake_game_controller.md
Name: snake_game_controller

Overview:
- Game-level controller directly downstream of the snake position stage; it consumes that stage's head coordinate and collision flag.
- Closes the loop by driving the position stage's length, step size (velocity) and apple coordinates.
- Owns the IDLE/SPAWN/PLAY/OVER game FSM, apple-eat detection, LFSR-based apple placement, score and speed ramp.

Parameters:
- INIT_LEN, 3, snake length after reset and on restart.
- MAX_LEN, 99, length saturation value (99 body segments).
- HIT_RADIUS, 10, eat window: |dx| < HIT_RADIUS and |dy| < HIT_RADIUS.
- X_MIN, 20 / X_MAX, 619, inclusive legal apple x range.
- Y_MIN, 20 / Y_MAX, 459, inclusive legal apple y range.
- SPEED_STEP, 5, score interval between velocity increments.
- VEL_MAX, 8, velocity cap.
- LFSR_SEED, 20'hACE1F, nonzero LFSR reset value.
- APPLE_TIMEOUT_TICKS, 600, ticks before forced respawn (optional feature only).

Ports:
- clock  in  1  system clock
- reset  in  1  reset
- tick  in  1  one-cycle game-step strobe, aligned with the position stage update
- start  in  1  start/restart request, level, sampled every clock
- head_x  in  10  snake head x
- head_y  in  10  snake head y
- collision  in  1  wall/self collision from the position stage
- length  out  10  current snake length
- velocity  out  4  pixels per step
- x_apple  out  10  apple x
- y_apple  out  10  apple y
- score  out  16  apples eaten
- game_over  out  1  high in OVER
- state  out  2  IDLE=0, SPAWN=1, PLAY=2, OVER=3

Behaviour:
- Reset is asynchronous and active-high; clock is clock.
- Reset values: state IDLE, length INIT_LEN, velocity 1, x_apple 480, y_apple 240, score 0, game_over 0, LFSR = LFSR_SEED.
- All outputs are registered.
- LFSR: 20-bit Fibonacci, taps x^20+x^17+1, shifts every clock in every state; never zero.
- Apple candidate: cx = lfsr[9:0], cy = {1'b0, lfsr[18:10]}.
- IDLE: start=1 -> SPAWN on the next clock.
- SPAWN: each clock, test the candidate.
  - Accept when X_MIN<=cx<=X_MAX, Y_MIN<=cy<=Y_MAX, and (|cx-head_x| >= 2*HIT_RADIUS or |cy-head_y| >= 2*HIT_RADIUS).
  - On accept: latch x_apple/y_apple and go to PLAY the same edge. Otherwise stay in SPAWN.
  - tick is ignored in SPAWN.
- PLAY: evaluated only on tick=1.
  - collision=1 -> OVER. Collision has priority over eat.
  - Else if |head_x-x_apple| < HIT_RADIUS and |head_y-y_apple| < HIT_RADIUS (11-bit signed differences):
    - length = min(length+1, MAX_LEN); score = score+1, saturating at 16'hFFFF.
    - If the new score is a multiple of SPEED_STEP, velocity = min(velocity+1, VEL_MAX).
    - Go to SPAWN.
- OVER: game_over=1; all values hold.
  - start=1 -> length INIT_LEN, velocity 1, score 0, go to SPAWN; game_over clears the same edge.
- start is ignored in SPAWN and PLAY.
- Reset mid-SPAWN or mid-PLAY returns every output to its reset value in the same cycle.

Optional Feature:
- Macro: SNAKE_APPLE_TIMEOUT_EN.
- Defined:
  - A 10-bit tick counter clears on entry to PLAY and counts ticks in PLAY.
  - When it reaches APPLE_TIMEOUT_TICKS with no eat, go to SPAWN with no score or length change.
  - Collision and eat both take priority over timeout on the same tick.
- Undefined: no counter; the apple persists until eaten.

Decomposition:
- Package snake_pkg holds:
  - the 2-bit state encoding;
  - screen constants 640/480;
  - the default HIT_RADIUS;
  - the LFSR tap constant.
- Sub-module snake_lfsr20 (seed parameter, enable, 20-bit state output) is instantiated once.
- FSM, eat detection and counters stay in the top module.

Test Plan:
- Reset asserted, then released -> state=0, length=3, velocity=1, apple (480,240), score=0; assert reset mid-PLAY -> same values immediately, without waiting for a clock.
- start pulse, head (320,120) -> SPAWN, then PLAY within N clocks; latched apple lies inside [20..619]x[20..459], is 20 or more px from the head on some axis, and matches the bench LFSR model.
- In PLAY, force head = apple+(9,-9) and pulse tick -> length 4, score 1, SPAWN; head = apple+(10,0) -> no eat.
- Five eats -> velocity 2; 40 eats -> velocity capped at 8; preload length 99 and eat -> length stays 99.
- collision=1 and eat-overlap on the same tick -> OVER, game_over=1, score unchanged; start -> length 3, score 0, velocity 1, SPAWN.
- With SNAKE_APPLE_TIMEOUT_EN and APPLE_TIMEOUT_TICKS=4 -> 4 ticks with no eat -> SPAWN, score unchanged; without the macro -> stays in PLAY.
